regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-port arbiter and sequencer for the 32×32 MIPS register file. It shares the register file's single write port (`regWrite`/`writeRegnum`/`writeData`) between two writeback requesters:
- requester 0: ALU result path
- requester 1: memory-load result path

Each requester has a one-entry hold buffer and a valid/ready handshake. Grants alternate round-robin, with same-destination writes kept in age order. The block sits between the execute/memory stages and `RegisterFile`, and drives its write port directly.

## Interface
Parameters:
- `DATA_W`, default 32: register data width.
- `ADDR_W`, default 5: register number width.

Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  rising-edge clock shared with the register file.
- `reset`  in  1  synchronous, active-high reset.

Requester 0 (ALU writeback):
- `req0_valid`  in  1  write request.
- `req0_ready`  out  1  buffer can accept this cycle.
- `req0_num`  in  ADDR_W  destination register.
- `req0_data`  in  DATA_W  write data.

Requester 1 (load writeback):
- `req1_valid`, `req1_ready`, `req1_num`, `req1_data`: same meaning as requester 0.

Register-file write port:
- `rf_regWrite`  out  1  write enable to the register file.
- `rf_writeRegnum`  out  ADDR_W  write register number.
- `rf_writeData`  out  DATA_W  write data.

Read path and status:
- `rd1_num`, `rd2_num`  in  ADDR_W  read register numbers (the same values driven to `readReg1_num`/`readReg2_num`).
- `rf_rdata1`, `rf_rdata2`  in  DATA_W  `readData1`/`readData2` from the register file.
- `rdata1`, `rdata2`  out  DATA_W  read data delivered to the datapath.
- `busy`  out  1  at least one hold buffer is full.

## Operation
- Accept: a handshake completes when `reqN_valid && reqN_ready` at a rising edge; `{num, data}` is captured into hold buffer N.
  - `reqN_ready = !fullN || grantN`, so an uncontended requester can sustain one write per cycle.
- Register 0: a request with `num == 0` completes the handshake but the buffer does not become full. It never reaches the port and never consumes a grant.
- Arbitration is combinational from buffer state each cycle:
  - One buffer full: that buffer is granted.
  - Both full, different destinations: grant the requester selected by the round-robin pointer `rr`. After the grant, `rr` points to the other requester.
  - Both full, same destination: grant the older buffer, as tracked by the `older` flag. `rr` is unchanged.
  - Age rule: an entry captured at an earlier edge is older. Entries captured at the same edge treat requester 0 as older.
- Port drive: `rf_regWrite = grant0 | grant1`, and `rf_writeRegnum`/`rf_writeData` come from the granted buffer. When there is no grant, the port drives all zeros.
- Drain: the granted buffer clears at the edge that writes the register file. It may refill at that same edge.
- `busy = full0 | full1`.
- Read path: see Configuration.

## Timing
- Request accepted at edge E0 → written into the register file at edge E1 if uncontended. Worst case (loses arbitration) is edge E2.
- A loser is always granted on the next cycle, so there is no starvation and the maximum wait is 1 cycle.
- Reset (synchronous):
  - At the reset edge: buffers become empty, `rr` = 0, `older` = 0.
  - While `reset` is high: `reqN_ready` = 0, `rf_regWrite` = 0, `rf_writeRegnum` = 0, `rf_writeData` = 0, `busy` = 0.
- Reset mid-operation: pending buffered writes are discarded and no write is issued in any reset cycle.
- Simultaneous grant-and-refill of the same buffer: the new entry is treated as younger than any entry already held in the other buffer.

## Configuration
Macro `RFARB_BYPASS_EN`:
- Defined: `rdataK` forwards pending data when `rdK_num != 0` matches a full buffer's `num`. If both buffers match, the younger entry's data is forwarded; otherwise `rdataK = rf_rdataK`.
- Undefined: `rdataK = rf_rdataK` as a pure passthrough. The ports exist in both builds.

## Structure
- Package `regfile_arb_pkg`:
  - `DATA_W`, `ADDR_W` defaults.
  - `wb_entry_t` struct `{num, data}`.
  - `REG_ZERO` constant.
- Sub-module `wb_hold_buf`: one-entry buffer holding the full flag and entry, with load and clear inputs. It is instantiated twice.
- Arbitration, age tracking, port mux and bypass live in the top level.

## Test plan
- Single write: `req0` writes (num 5, data 0xDEADBEEF) at edge E0 → `rf_regWrite` = 1 with num 5 and data 0xDEADBEEF during the cycle ending at E1. `busy` = 0 after E1.
- Contention: both requesters are valid at the same edge, with `req0` → r3 = 0x11 and `req1` → r4 = 0x22 and `rr` = 0 → r3 is written first and r4 on the next cycle. `rr` then points to requester 0.
- Same destination: `req1` → r7 = 0xA is accepted one edge before `req0` → r7 = 0xB, and both are pending → r7 = 0xA is written first, then 0xB. The final r7 read is 0xB.
- Register 0: `req0` num 0, data 0xFFFF → handshake completes, `rf_regWrite` stays 0, `busy` stays 0.
- Bypass (`RFARB_BYPASS_EN` defined): r9 is pending with 0x55 and `rd1_num` = 9 → `rdata1` = 0x55. With the macro undefined → `rdata1` = `rf_rdata1`.
- Reset: `reset` is asserted while both buffers are full → no write is issued in the reset cycle. Afterward `busy` = 0, and the first post-reset write is taken from new requests only.

Source files
------------

// File: rtl/regfile_arb_pkg.sv
// Shared widths, the hold-buffer entry layout and the register-zero constant
// used by the register-file writeback arbiter.
package regfile_arb_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int REG_ZERO = 0;

    typedef struct packed {
        logic [ADDR_W-1:0] num;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_hold_buf.sv
// One-entry writeback hold buffer: a full flag plus the captured {num, data}.
// A load wins over a clear so a granted buffer can refill at its drain edge.
module wb_hold_buf
    import regfile_arb_pkg::*;
#(
    parameter int ENTRY_W = $bits(wb_entry_t)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               clear,
    input  logic [ENTRY_W-1:0] loadEntry,
    output logic               full,
    output logic [ENTRY_W-1:0] entry
);

    logic               fullReg;
    logic [ENTRY_W-1:0] entryReg;

    always_ff @(posedge clk) begin
        if (reset) begin
            fullReg  <= 1'b0;
            entryReg <= '0;
        end else begin
            if (load) begin
                fullReg  <= 1'b1;
                entryReg <= loadEntry;
            end else if (clear) begin
                fullReg  <= 1'b0;
            end
        end
    end

    assign full  = fullReg;
    assign entry = entryReg;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port between the ALU and load
// writeback paths. Define RFARB_BYPASS_EN to forward pending writes to reads.
module regfile_wb_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int DATA_W = regfile_arb_pkg::DATA_W,
    parameter int ADDR_W = regfile_arb_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_num,
    input  logic [DATA_W-1:0] req0_data,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_num,
    input  logic [DATA_W-1:0] req1_data,

    output logic              rf_regWrite,
    output logic [ADDR_W-1:0] rf_writeRegnum,
    output logic [DATA_W-1:0] rf_writeData,

    input  logic [ADDR_W-1:0] rd1_num,
    input  logic [ADDR_W-1:0] rd2_num,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,

    output logic              busy
);

    localparam int ENTRY_W = ADDR_W + DATA_W;

    logic [1:0]         reqValid;
    logic [1:0]         reqReady;
    logic [1:0]         accept;
    logic [1:0]         load;
    logic [1:0]         full;
    logic [1:0]         grant;
    logic [ADDR_W-1:0]  reqNum  [2];
    logic [DATA_W-1:0]  reqData [2];
    logic [ENTRY_W-1:0] bufEntry [2];
    logic [ADDR_W-1:0]  bufNum  [2];
    logic [DATA_W-1:0]  bufData [2];

    logic               rrReg;
    logic               olderReg;     // 1: buffer 1 holds the older entry
    logic               sameDest;

    logic [ADDR_W-1:0]  rdNum    [2];
    logic [DATA_W-1:0]  rfRdata  [2];
    logic [DATA_W-1:0]  rdataOut [2];

    assign reqValid   = {req1_valid, req0_valid};
    assign reqNum[0]  = req0_num;
    assign reqNum[1]  = req1_num;
    assign reqData[0] = req0_data;
    assign reqData[1] = req1_data;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_buf
            assign reqReady[gi] = ~reset & (~full[gi] | grant[gi]);
            assign accept[gi]   = reqValid[gi] & reqReady[gi];
            // Writes to r0 complete the handshake but are dropped here.
            assign load[gi]     = accept[gi] & (reqNum[gi] != ADDR_W'(REG_ZERO));

            wb_hold_buf #(
                .ENTRY_W (ENTRY_W)
            ) u_hold_buf (
                .clk       (clk),
                .reset     (reset),
                .load      (load[gi]),
                .clear     (grant[gi]),
                .loadEntry ({reqNum[gi], reqData[gi]}),
                .full      (full[gi]),
                .entry     (bufEntry[gi])
            );

            assign bufNum[gi]  = bufEntry[gi][ENTRY_W-1 -: ADDR_W];
            assign bufData[gi] = bufEntry[gi][DATA_W-1:0];
        end
    endgenerate

    assign req0_ready = reqReady[0];
    assign req1_ready = reqReady[1];

    assign sameDest = full[0] & full[1] & (bufNum[0] == bufNum[1]);

    always_comb begin
        grant = 2'b00;
        if (!reset) begin
            if (full == 2'b11) begin
                if (sameDest) begin
                    grant = olderReg ? 2'b10 : 2'b01;
                end else begin
                    grant = rrReg ? 2'b10 : 2'b01;
                end
            end else begin
                grant = full;
            end
        end
    end

    // A freshly loaded entry is always the younger one, including a refill
    // of the buffer being drained at the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            rrReg    <= 1'b0;
            olderReg <= 1'b0;
        end else begin
            if ((grant != 2'b00) && !sameDest) begin
                rrReg <= grant[0];
            end
            if (load[0] && !load[1]) begin
                olderReg <= 1'b1;
            end else if (load[1]) begin
                olderReg <= 1'b0;
            end
        end
    end

    always_comb begin
        rf_regWrite    = |grant;
        rf_writeRegnum = '0;
        rf_writeData   = '0;
        if (grant[1]) begin
            rf_writeRegnum = bufNum[1];
            rf_writeData   = bufData[1];
        end else if (grant[0]) begin
            rf_writeRegnum = bufNum[0];
            rf_writeData   = bufData[0];
        end
    end

    assign busy = ~reset & (|full);

    assign rdNum[0]   = rd1_num;
    assign rdNum[1]   = rd2_num;
    assign rfRdata[0] = rf_rdata1;
    assign rfRdata[1] = rf_rdata2;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_read
`ifdef RFARB_BYPASS_EN
            logic [1:0]        hit;
            logic [DATA_W-1:0] fwd;

            always_comb begin
                hit[0] = full[0] && (bufNum[0] == rdNum[gi]) && (rdNum[gi] != ADDR_W'(REG_ZERO));
                hit[1] = full[1] && (bufNum[1] == rdNum[gi]) && (rdNum[gi] != ADDR_W'(REG_ZERO));
                fwd    = rfRdata[gi];
                if (hit == 2'b11) begin
                    fwd = olderReg ? bufData[0] : bufData[1];
                end else if (hit[0]) begin
                    fwd = bufData[0];
                end else if (hit[1]) begin
                    fwd = bufData[1];
                end
            end

            assign rdataOut[gi] = fwd;
`else
            assign rdataOut[gi] = rfRdata[gi];
`endif
        end
    endgenerate

`ifndef RFARB_BYPASS_EN
    logic unusedReadNums;
    assign unusedReadNums = ^{rdNum[0], rdNum[1]};
`endif

    assign rdata1 = rdataOut[0];
    assign rdata2 = rdataOut[1];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus random
// traffic compared against a queue-of-ages reference model.
module tb_regfile_wb_arbiter;
    import regfile_arb_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
`ifdef RFARB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          req0_valid, req1_valid, req0_ready, req1_ready;
    logic [AW-1:0] req0_num, req1_num;
    logic [DW-1:0] req0_data, req1_data;
    logic          rf_regWrite;
    logic [AW-1:0] rf_writeRegnum;
    logic [DW-1:0] rf_writeData;
    logic [AW-1:0] rd1_num, rd2_num;
    logic [DW-1:0] rf_rdata1, rf_rdata2, rdata1, rdata2;
    logic          busy;

    int checks = 0;
    int errors = 0;

    regfile_wb_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_num(req0_num), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_num(req1_num), .req1_data(req1_data),
        .rf_regWrite(rf_regWrite), .rf_writeRegnum(rf_writeRegnum), .rf_writeData(rf_writeData),
        .rd1_num(rd1_num), .rd2_num(rd2_num), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .rdata1(rdata1), .rdata2(rdata2), .busy(busy)
    );

    // Register-file stand-in fed by the DUT's write port.
    logic [DW-1:0] rfArr [32];
    assign rf_rdata1 = rfArr[rd1_num];
    assign rf_rdata2 = rfArr[rd2_num];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) rfArr[i] <= '0;
        end else if (rf_regWrite) begin
            rfArr[rf_writeRegnum] <= rf_writeData;
        end
    end

    // Reference model: each pending entry carries its capture age.
    logic          mFull [2];
    logic [AW-1:0] mNum  [2];
    logic [DW-1:0] mData [2];
    int            mSeq  [2];
    logic          mRr;
    int            mCyc;

    logic [1:0]    eGrant;
    logic          eRdy [2];
    logic          eWr, eBusy;
    logic [AW-1:0] eNum;
    logic [DW-1:0] eData, eRd1, eRd2;

    function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] rn, input logic [DW-1:0] rfv);
        logic [DW-1:0] v = rfv;
        int best = -1;
        for (int i = 0; i < 2; i++) begin
            if (BYP && mFull[i] && rn != 0 && mNum[i] == rn && mSeq[i] > best) begin
                best = mSeq[i];
                v = mData[i];
            end
        end
        return v;
    endfunction

    task automatic model_expect();
        eGrant = 2'b00;
        if (!reset) begin
            if (mFull[0] && mFull[1]) begin
                if (mNum[0] == mNum[1]) eGrant = (mSeq[0] < mSeq[1]) ? 2'b01 : 2'b10;
                else                    eGrant = mRr ? 2'b10 : 2'b01;
            end else begin
                eGrant = {mFull[1], mFull[0]};
            end
        end
        for (int i = 0; i < 2; i++) eRdy[i] = !reset && (!mFull[i] || eGrant[i]);
        eWr   = (eGrant != 2'b00);
        eNum  = eGrant[0] ? mNum[0]  : (eGrant[1] ? mNum[1]  : '0);
        eData = eGrant[0] ? mData[0] : (eGrant[1] ? mData[1] : '0);
        eBusy = !reset && (mFull[0] || mFull[1]);
        eRd1  = exp_read(rd1_num, rf_rdata1);
        eRd2  = exp_read(rd2_num, rf_rdata2);
    endtask

    task automatic model_update();
        logic          v [2];
        logic [AW-1:0] n [2];
        logic [DW-1:0] d [2];
        logic          sameBoth;
        v[0] = req0_valid; n[0] = req0_num; d[0] = req0_data;
        v[1] = req1_valid; n[1] = req1_num; d[1] = req1_data;
        if (reset) begin
            mFull[0] = 1'b0; mFull[1] = 1'b0; mRr = 1'b0;
        end else begin
            sameBoth = mFull[0] && mFull[1] && (mNum[0] == mNum[1]);
            if (eGrant != 2'b00 && !sameBoth) mRr = eGrant[0];
            for (int i = 0; i < 2; i++) begin
                if (eGrant[i]) mFull[i] = 1'b0;
                if (v[i] && eRdy[i] && n[i] != 0) begin
                    mFull[i] = 1'b1; mNum[i] = n[i]; mData[i] = d[i]; mSeq[i] = mCyc * 2 + i;
                end
            end
        end
        mCyc++;
    endtask

    task automatic drive(input logic v0, input logic [AW-1:0] n0, input logic [DW-1:0] d0,
                         input logic v1, input logic [AW-1:0] n1, input logic [DW-1:0] d1);
        req0_valid = v0; req0_num = n0; req0_data = d0;
        req1_valid = v1; req1_num = n1; req1_data = d1;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic settle();
        #1;
        model_expect();
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset = 1'b1; idle(); settle(); step(); reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, 5'd3, 32'h1, 1'b1, 5'd4, 32'h2);
        settle();
        checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_ready0 got %0b want 0", req0_ready); end
        checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready1 got %0b want 0", req1_ready); end
        checks++; if (rf_regWrite !== 1'b0) begin errors++; $display("FAIL reset_wr got %0b want 0", rf_regWrite); end
        checks++; if (rf_writeRegnum !== 5'd0 || rf_writeData !== 32'd0) begin errors++; $display("FAIL reset_port got %0d/%h want 0/0", rf_writeRegnum, rf_writeData); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        step();
        reset = 1'b0; idle(); settle();
        checks++; if (busy !== 1'b0 || rf_regWrite !== 1'b0) begin errors++; $display("FAIL post_reset_idle busy %0b wr %0b want 0 0", busy, rf_regWrite); end
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready0 got %0b want 1", req0_ready); end
        step();
    endtask

    task automatic test_single_write();
        apply_reset();
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0); settle();
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %0b want 1", req0_ready); end
        step(); idle(); settle();
        checks++; if (rf_regWrite !== 1'b1 || rf_writeRegnum !== 5'd5 || rf_writeData !== 32'hDEADBEEF)
            begin errors++; $display("FAIL single_port got %0b/%0d/%h want 1/5/deadbeef", rf_regWrite, rf_writeRegnum, rf_writeData); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_pending got %0b want 1", busy); end
        step(); settle();
        checks++; if (busy !== 1'b0 || rf_regWrite !== 1'b0) begin errors++; $display("FAIL single_drained busy %0b wr %0b want 0 0", busy, rf_regWrite); end
        step();
    endtask

    task automatic test_contention();
        apply_reset();
        drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22); settle(); step();
        idle(); settle();
        checks++; if (rf_regWrite !== 1'b1 || rf_writeRegnum !== 5'd3 || rf_writeData !== 32'h11)
            begin errors++; $display("FAIL contend_first got %0b/%0d/%h want 1/3/11", rf_regWrite, rf_writeRegnum, rf_writeData); end
        checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL contend_loser_ready got %0b want 0", req1_ready); end
        step(); settle();
        checks++; if (rf_regWrite !== 1'b1 || rf_writeRegnum !== 5'd4 || rf_writeData !== 32'h22)
            begin errors++; $display("FAIL contend_second got %0b/%0d/%h want 1/4/22", rf_regWrite, rf_writeRegnum, rf_writeData); end
        step();
        drive(1'b1, 5'd6, 32'h66, 1'b1, 5'd8, 32'h88); settle(); step();
        idle(); settle();
        checks++; if (rf_writeRegnum !== 5'd6) begin errors++; $display("FAIL contend_rr_back got %0d want 6", rf_writeRegnum); end
        step(); settle(); step();
    endtask

    task automatic test_same_dest();
        apply_reset();
        drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd7, 32'hA); settle(); step();
        drive(1'b1, 5'd7, 32'hB, 1'b0, '0, '0); settle();
        checks++; if (rf_writeRegnum !== 5'd1 || req0_ready !== 1'b1) begin errors++; $display("FAIL same_setup num %0d ready0 %0b want 1 1", rf_writeRegnum, req0_ready); end
        step(); idle(); settle();
        checks++; if (rf_writeRegnum !== 5'd7 || rf_writeData !== 32'hA) begin errors++; $display("FAIL same_older got %0d/%h want 7/a", rf_writeRegnum, rf_writeData); end
        step(); settle();
        checks++; if (rf_writeRegnum !== 5'd7 || rf_writeData !== 32'hB) begin errors++; $display("FAIL same_younger got %0d/%h want 7/b", rf_writeRegnum, rf_writeData); end
        step();
        rd1_num = 5'd7; settle();
        checks++; if (rdata1 !== 32'hB) begin errors++; $display("FAIL same_final_read got %h want b", rdata1); end
        rd1_num = '0;
    endtask

    task automatic test_reg_zero();
        apply_reset();
        drive(1'b1, 5'd0, 32'hFFFF, 1'b0, '0, '0); settle();
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL r0_ready got %0b want 1", req0_ready); end
        step(); idle(); settle();
        checks++; if (rf_regWrite !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL r0_dropped wr %0b busy %0b want 0 0", rf_regWrite, busy); end
        step();
    endtask

    task automatic test_bypass();
        logic [DW-1:0] want;
        apply_reset();
        rd1_num = 5'd9;
        drive(1'b1, 5'd9, 32'h55, 1'b0, '0, '0); settle(); step();
        idle(); settle();
        want = BYP ? 32'h55 : rf_rdata1;
        checks++; if (rdata1 !== want) begin errors++; $display("FAIL bypass_rdata1 got %h want %h", rdata1, want); end
        step();
        rd1_num = '0;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44); settle(); step();
        reset = 1'b1;
        drive(1'b1, 5'd10, 32'hAA, 1'b1, 5'd11, 32'hBB); settle();
        checks++; if (rf_regWrite !== 1'b0 || busy !== 1'b0 || req0_ready !== 1'b0)
            begin errors++; $display("FAIL midreset_cycle wr %0b busy %0b rdy0 %0b want 0 0 0", rf_regWrite, busy, req0_ready); end
        step();
        reset = 1'b0; idle(); settle();
        checks++; if (rf_regWrite !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midreset_after wr %0b busy %0b want 0 0", rf_regWrite, busy); end
        step();
        drive(1'b0, '0, '0, 1'b1, 5'd12, 32'h77); settle(); step();
        idle(); settle();
        checks++; if (rf_regWrite !== 1'b1 || rf_writeRegnum !== 5'd12 || rf_writeData !== 32'h77)
            begin errors++; $display("FAIL midreset_new got %0b/%0d/%h want 1/12/77", rf_regWrite, rf_writeRegnum, rf_writeData); end
        step();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 49) == 0);
            drive($urandom_range(0, 9) < 7, AW'($urandom_range(0, 3)), $urandom,
                  $urandom_range(0, 9) < 7, AW'($urandom_range(0, 3)), $urandom);
            rd1_num = AW'($urandom_range(0, 3));
            rd2_num = AW'($urandom_range(0, 3));
            settle();
            checks++; if (req0_ready !== eRdy[0]) begin errors++; $display("FAIL rnd%0d ready0 got %0b want %0b", c, req0_ready, eRdy[0]); end
            checks++; if (req1_ready !== eRdy[1]) begin errors++; $display("FAIL rnd%0d ready1 got %0b want %0b", c, req1_ready, eRdy[1]); end
            checks++; if (rf_regWrite !== eWr) begin errors++; $display("FAIL rnd%0d wr got %0b want %0b", c, rf_regWrite, eWr); end
            checks++; if (rf_writeRegnum !== eNum) begin errors++; $display("FAIL rnd%0d num got %0d want %0d", c, rf_writeRegnum, eNum); end
            checks++; if (rf_writeData !== eData) begin errors++; $display("FAIL rnd%0d data got %h want %h", c, rf_writeData, eData); end
            checks++; if (busy !== eBusy) begin errors++; $display("FAIL rnd%0d busy got %0b want %0b", c, busy, eBusy); end
            checks++; if (rdata1 !== eRd1) begin errors++; $display("FAIL rnd%0d rdata1 got %h want %h", c, rdata1, eRd1); end
            checks++; if (rdata2 !== eRd2) begin errors++; $display("FAIL rnd%0d rdata2 got %h want %h", c, rdata2, eRd2); end
            step();
        end
        reset = 1'b0; idle(); rd1_num = '0; rd2_num = '0;
    endtask

    initial begin
        mFull[0] = 1'b0; mFull[1] = 1'b0;
        mNum[0] = '0; mNum[1] = '0; mData[0] = '0; mData[1] = '0;
        mSeq[0] = 0; mSeq[1] = 0; mRr = 1'b0; mCyc = 0;
        reset = 1'b1; idle(); rd1_num = '0; rd2_num = '0;
        @(negedge clk);
        test_reset();
        test_single_write();
        test_contention();
        test_same_dest();
        test_reg_zero();
        test_bypass();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
